// File: rtl/read_d_fetch.sv
// Request/response front-end between the search core and the read/D(i) ROM.
// One S1 register drives the ROM; results are queued in a small credit-checked FIFO.
module read_d_fetch #(
    parameter int Z_W        = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [7:0]     req_i,
    input  logic [Z_W-1:0] req_z,
    output logic           rom_ce,
    output logic [7:0]     rom_addr,
    input  logic [7:0]     rom_d_i,
    input  logic [1:0]     rom_read_i,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [7:0]     rsp_i,
    output logic [Z_W-1:0] rsp_z,
    output logic [1:0]     rsp_sym,
    output logic [7:0]     rsp_d,
    output logic           rsp_prune,
    output logic           rsp_done,
    output logic [15:0]    rsp_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam int CMP_W = ((Z_W > 8) ? Z_W : 8) + 1;

    logic           r_s1_valid;
    logic [7:0]     r_s1_i;
    logic [Z_W-1:0] r_s1_z;

    logic [7:0]     r_mem_i     [FIFO_DEPTH];
    logic [Z_W-1:0] r_mem_z     [FIFO_DEPTH];
    logic [1:0]     r_mem_sym   [FIFO_DEPTH];
    logic [7:0]     r_mem_d     [FIFO_DEPTH];
    logic           r_mem_prune [FIFO_DEPTH];
    logic           r_mem_done  [FIFO_DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_rsp_cnt;

    logic             w_pop;
    logic             w_push;
    logic             w_accept;
    logic [OCC_W-1:0] w_occ;
    logic             w_is_root;
    logic [CMP_W-1:0] w_z_ext;
    logic [CMP_W-1:0] w_d_ext;
    logic             w_z_neg;
    logic             w_z_lt_d;
    logic             w_prune;
    logic             w_done;
    logic [1:0]       w_sym;
    logic [7:0]       w_d;

    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_push    = r_s1_valid && !flush;

    // Occupancy after this edge decides whether one more request fits.
    assign w_occ = OCC_W'(r_count)
                 + OCC_W'(r_s1_valid)
                 - OCC_W'(w_pop);

    assign req_ready = !flush
                    && (w_occ < OCC_W'(FIFO_DEPTH));
    assign w_accept  = req_valid && req_ready;

    assign rom_ce   = r_s1_valid;
    assign rom_addr = r_s1_valid ? r_s1_i : 8'h00;

    assign w_is_root = (r_s1_i == 8'hff);
    assign w_z_ext   = CMP_W'($signed(r_s1_z));
    assign w_d_ext   = CMP_W'(rom_d_i);
    assign w_z_neg   = r_s1_z[Z_W-1];
    assign w_z_lt_d  = $signed(w_z_ext) < $signed(w_d_ext);

    assign w_prune = w_z_neg || (!w_is_root && w_z_lt_d);
    assign w_done  = w_is_root && !w_z_neg;
    assign w_sym   = w_is_root ? 2'b00 : rom_read_i;
    assign w_d     = w_is_root ? 8'h00 : rom_d_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_i     <= '0;
            r_s1_z     <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_i     <= req_i;
            r_s1_z     <= req_z;
        end else begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_mem_i[k]     <= '0;
                r_mem_z[k]     <= '0;
                r_mem_sym[k]   <= '0;
                r_mem_d[k]     <= '0;
                r_mem_prune[k] <= 1'b0;
                r_mem_done[k]  <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_i[r_wr_ptr]     <= r_s1_i;
            r_mem_z[r_wr_ptr]     <= r_s1_z;
            r_mem_sym[r_wr_ptr]   <= w_sym;
            r_mem_d[r_wr_ptr]     <= w_d;
            r_mem_prune[r_wr_ptr] <= w_prune;
            r_mem_done[r_wr_ptr]  <= w_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_cnt <= '0;
        end else if (flush) begin
            r_rsp_cnt <= '0;
        end else if (w_pop && (r_rsp_cnt != 16'hffff)) begin
            r_rsp_cnt <= r_rsp_cnt + 16'd1;
        end
    end

    // Empty FIFO presents zeros rather than a stale slot.
    assign rsp_i     = rsp_valid ? r_mem_i[r_rd_ptr]     : '0;
    assign rsp_z     = rsp_valid ? r_mem_z[r_rd_ptr]     : '0;
    assign rsp_sym   = rsp_valid ? r_mem_sym[r_rd_ptr]   : '0;
    assign rsp_d     = rsp_valid ? r_mem_d[r_rd_ptr]     : '0;
    assign rsp_prune = rsp_valid ? r_mem_prune[r_rd_ptr] : 1'b0;
    assign rsp_done  = rsp_valid ? r_mem_done[r_rd_ptr]  : 1'b0;
    assign rsp_cnt   = r_rsp_cnt;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n || flush)
        !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH)))
    );

endmodule

// File: tb/tb_read_d_fetch.sv
// Randomized bench for read_d_fetch with a queue-based reference model.
// Directed cases pin literal results; a per-cycle compare checks everything else.
module tb_read_d_fetch;

    localparam int Z_W   = 8;
    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [7:0]     req_i = '0;
    logic [Z_W-1:0] req_z = '0;
    logic           rom_ce;
    logic [7:0]     rom_addr;
    logic [7:0]     rom_d_i;
    logic [1:0]     rom_read_i;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [7:0]     rsp_i;
    logic [Z_W-1:0] rsp_z;
    logic [1:0]     rsp_sym;
    logic [7:0]     rsp_d;
    logic           rsp_prune;
    logic           rsp_done;
    logic [15:0]    rsp_cnt;

    logic [7:0] rom_d   [256];
    logic [1:0] rom_sym [256];

    assign rom_d_i    = rom_d[rom_addr];
    assign rom_read_i = rom_sym[rom_addr];

    always #5 clk = ~clk;

    read_d_fetch #(.Z_W(Z_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_i(req_i), .req_z(req_z),
        .rom_ce(rom_ce), .rom_addr(rom_addr),
        .rom_d_i(rom_d_i), .rom_read_i(rom_read_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_i(rsp_i), .rsp_z(rsp_z), .rsp_sym(rsp_sym),
        .rsp_d(rsp_d), .rsp_prune(rsp_prune),
        .rsp_done(rsp_done), .rsp_cnt(rsp_cnt)
    );

    typedef struct {
        logic [7:0]     i;
        logic [Z_W-1:0] z;
        logic [1:0]     sym;
        logic [7:0]     d;
        logic           prune;
        logic           done;
    } ent_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [7:0] i, input logic [Z_W-1:0] z);
        ent_t e;
        int zi;
        int di;
        zi = $signed(z);
        di = int'(rom_d[i]);
        e.i = i;
        e.z = z;
        e.sym = (i == 8'hff) ? 2'b00 : rom_sym[i];
        e.d = (i == 8'hff) ? 8'h00 : rom_d[i];
        e.prune = (zi < 0) || (i != 8'hff && zi < di);
        e.done = (i == 8'hff) && (zi >= 0);
        return e;
    endfunction

    ent_t           mq[$];
    bit             m_s1_v = 0;
    logic [7:0]     m_s1_i = '0;
    logic [Z_W-1:0] m_s1_z = '0;
    int             m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        bit pop;
        bit acc;
        int occ;
        if (!rst_n) begin
            mq.delete();
            m_s1_v = 0;
            m_cnt = 0;
        end else begin
            pop = (mq.size() > 0) && rsp_ready;
            occ = mq.size() + int'(m_s1_v) - int'(pop);
            acc = req_valid && !flush && (occ < DEPTH);
            if (flush) begin
                mq.delete();
                m_s1_v = 0;
                m_cnt = 0;
            end else begin
                if (pop) begin
                    void'(mq.pop_front());
                    if (m_cnt < 65535) m_cnt++;
                end
                if (m_s1_v) mq.push_back(mk(m_s1_i, m_s1_z));
                m_s1_v = acc;
                if (acc) begin
                    m_s1_i = req_i;
                    m_s1_z = req_z;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit pop;
        int occ;
        if (rst_n) begin
            pop = (mq.size() > 0) && rsp_ready;
            occ = mq.size() + int'(m_s1_v) - int'(pop);
            chk("req_ready", 32'(req_ready), 32'(!flush && occ < DEPTH));
            chk("rsp_valid", 32'(rsp_valid), 32'(mq.size() > 0));
            chk("rom_ce", 32'(rom_ce), 32'(m_s1_v));
            chk("rom_addr", 32'(rom_addr), m_s1_v ? 32'(m_s1_i) : 32'd0);
            chk("rsp_cnt", 32'(rsp_cnt), 32'(m_cnt));
            if (mq.size() > 0) begin
                chk("rsp_i", 32'(rsp_i), 32'(mq[0].i));
                chk("rsp_z", 32'(rsp_z), 32'(mq[0].z));
                chk("rsp_sym", 32'(rsp_sym), 32'(mq[0].sym));
                chk("rsp_d", 32'(rsp_d), 32'(mq[0].d));
                chk("rsp_prune", 32'(rsp_prune), 32'(mq[0].prune));
                chk("rsp_done", 32'(rsp_done), 32'(mq[0].done));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] i, input logic [Z_W-1:0] z);
        bit ok;
        ok = 0;
        req_valid = 1'b1;
        req_i = i;
        req_z = z;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = req_ready;
            tick();
        end
        req_valid = 1'b0;
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic lit(input logic [7:0] i, input logic [Z_W-1:0] z,
                       input logic [1:0] es, input logic [7:0] ed,
                       input logic ep, input logic edn);
        rsp_ready = 1'b0;
        send(i, z);
        tick();
        chk("lit_valid", 32'(rsp_valid), 32'd1);
        chk("lit_i", 32'(rsp_i), 32'(i));
        chk("lit_sym", 32'(rsp_sym), 32'(es));
        chk("lit_d", 32'(rsp_d), 32'(ed));
        chk("lit_prune", 32'(rsp_prune), 32'(ep));
        chk("lit_done", 32'(rsp_done), 32'(edn));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic rand_phase(input int n);
        for (int c = 0; c < n; c++) begin
            flush = ($urandom_range(0, 99) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            req_i = ($urandom_range(0, 7) == 0) ? 8'hff : 8'($urandom_range(0, 255));
            req_z = 8'($signed($urandom_range(0, 12)) - 3);
            if ($urandom_range(0, 15) == 0) req_z = 8'($urandom_range(0, 255));
            tick();
        end
        flush = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        int k;
        logic [7:0] head;
        for (int a = 0; a < 256; a++) begin
            rom_d[a] = 8'($urandom_range(0, 9));
            rom_sym[a] = 2'($urandom_range(0, 3));
        end
        rom_d[255] = 8'h5a;
        rom_sym[255] = 2'b11;
        rom_d[5] = 8'd1;
        rom_sym[5] = 2'b10;

        #3;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_cnt", 32'(rsp_cnt), 32'd0);
        chk("rst_rom_ce", 32'(rom_ce), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_rsp_i", 32'(rsp_i), 32'd0);
        chk("rst_rsp_d", 32'(rsp_d), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        lit(8'd5, 8'd2, 2'b10, 8'd1, 1'b0, 1'b0);
        lit(8'd5, 8'd0, 2'b10, 8'd1, 1'b1, 1'b0);
        rom_d[5] = 8'd0;
        lit(8'd5, 8'hff, 2'b10, 8'd0, 1'b1, 1'b0);
        lit(8'hff, 8'd0, 2'b00, 8'd0, 1'b0, 1'b1);
        lit(8'hff, 8'hff, 2'b00, 8'd0, 1'b1, 1'b0);

        do_flush();
        chk("flush_cnt", 32'(rsp_cnt), 32'd0);
        rsp_ready = 1'b1;
        for (int s = 0; s < 10; s++) begin
            req_valid = 1'b1;
            req_i = 8'(s);
            req_z = 8'd4;
            @(negedge clk);
            chk("stream_ready", 32'(req_ready), 32'd1);
            tick();
        end
        req_valid = 1'b0;
        tick();
        chk("stream_tail_valid", 32'(rsp_valid), 32'd1);
        tick();
        tick();
        chk("stream_cnt", 32'(rsp_cnt), 32'd10);

        rsp_ready = 1'b0;
        k = 20;
        req_valid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            req_i = 8'(k);
            req_z = 8'd3;
            @(negedge clk);
            if (req_ready) k++;
            tick();
        end
        chk("stall_accepted", 32'(k), 32'd22);
        chk("stall_ready", 32'(req_ready), 32'd0);
        chk("stall_head", 32'(rsp_i), 32'd20);
        head = rsp_i;
        tick();
        tick();
        chk("stall_stable", 32'(rsp_i), 32'd20);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_ready", 32'(req_ready), 32'd1);
        tick();
        k++;
        while (k < 26) begin
            req_i = 8'(k);
            @(negedge clk);
            if (req_ready) k++;
            tick();
        end
        req_valid = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        chk("drain_cnt", 32'(rsp_cnt), 32'd16);
        chk("drain_empty", 32'(rsp_valid), 32'd0);

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            req_i = 8'(40 + t);
            tick();
        end
        req_valid = 1'b0;
        do_flush();
        chk("flush_valid", 32'(rsp_valid), 32'd0);
        chk("flush_cnt2", 32'(rsp_cnt), 32'd0);
        chk("flush_rom_ce", 32'(rom_ce), 32'd0);

        send(8'd7, 8'd5);
        do_flush();
        chk("flush_s1_ce", 32'(rom_ce), 32'd0);
        tick();
        chk("flush_s1_gone", 32'(rsp_valid), 32'd0);

        rand_phase(3000);

        req_valid = 1'b1;
        req_i = 8'd9;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        chk("arst_cnt", 32'(rsp_cnt), 32'd0);
        chk("arst_rom_ce", 32'(rom_ce), 32'd0);
        chk("arst_rom_addr", 32'(rom_addr), 32'd0);
        chk("arst_rsp_i", 32'(rsp_i), 32'd0);
        req_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("arst_no_stale", 32'(rsp_valid), 32'd0);
        end

        rand_phase(2000);
        rsp_ready = 1'b1;
        for (int t = 0; t < 6; t++) tick();
        chk("final_empty", 32'(rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
